lfsr_4b_checker: RTL and testbench
==================================

Name: lfsr_4b_checker

Overview:
- Receive-side companion to the 4-bit Galois LFSR generator.
- Consumes a stream of LFSR state words and self-synchronises to it by seeding from received data.
- Once locked, predicts each next word independently of the input ("flywheel"), then counts and flags mismatches.
- Used as an in-system sequence checker on datapaths driven by the LFSR generator.

Parameters:
- WIDTH, 4: LFSR word width.
- TAPS, 4'b0101: Galois feedback mask. next(s) = {s[WIDTH-2:0],1'b0} ^ (s[WIDTH-1] ? TAPS : 0). From seed 0001 this gives 0001→0010→0100→1000→0101→1010→0001 (period 6).
- LOCK_CNT, 2: consecutive correct predictions needed to declare lock, ≥1.
- LOSS_CNT, 3: consecutive mismatches while locked before lock is dropped, ≥1.
- ERRW, 16: error counter width.

Ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is a valid beat this cycle.
- in_data  in  WIDTH  received LFSR state word.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse for each mismatched beat while LOCKED.
- err_count  out  ERRW  saturating mismatch count.
- expected  out  WIDTH  predicted value of the next valid beat.

Behaviour:
- Reset (nrst=0 at a posedge): state=SEEK, locked=0, err_pulse=0, err_count=0, expected=0, match_run=0, miss_run=0. Reset mid-stream discards lock immediately.
- All outputs are registered. A response to beat k is visible the cycle after beat k's posedge.
- Cycles with in_valid=0 change nothing except: err_pulse clears to 0, and clr_cnt still applies.
- SEEK:
  - Valid word == 0 (lockup state) is ignored.
  - Valid nonzero word: expected<=next(in_data), match_run<=0, go to SYNC.
- SYNC:
  - Valid word == expected: expected<=next(in_data), match_run++.
    - If match_run+1 == LOCK_CNT, go to LOCKED with miss_run<=0.
  - Valid word != expected and nonzero: reseed with expected<=next(in_data), match_run<=0, stay in SYNC.
  - Valid zero word: go to SEEK.
  - No errors are counted in SEEK or SYNC.
- LOCKED:
  - Every valid beat: expected<=next(expected). Never reseed from in_data.
  - Match: miss_run<=0.
  - Mismatch: err_pulse<=1, err_count increments (saturates at all-ones), miss_run++.
    - If miss_run+1 == LOSS_CNT: go to SEEK, locked<=0. The mismatch that causes the loss is still counted.
- clr_cnt:
  - Forces err_count<=0 and takes priority over a simultaneous increment (result 0).
  - err_pulse is unaffected.
  - Does not change FSM state.
- Back-to-back valid beats are supported every cycle; no backpressure.

Optional Feature:
- Macro: LFSR_CHK_BITERR_EN.
- Defined:
  - Adds output bit_err_count, ERRW wide.
  - In LOCKED, each valid beat adds popcount(in_data ^ expected), saturating.
  - Reset value 0; cleared by clr_cnt with the same priority as err_count.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package lfsr_pkg holds:
  - FSM state enum: SEEK, SYNC, LOCKED.
  - Default WIDTH and TAPS constants.
  - A lfsr_next function, shared with the generator so both ends use one definition.
- One natural sub-module: lfsr_err_counter, a saturating counter with clear-priority. It is instantiated once for err_count and, under LFSR_CHK_BITERR_EN, once for bit_err_count.

Test Plan:
- Reset: hold nrst=0 for 2 clocks with in_valid=1, in_data=0101 → locked=0, err_pulse=0, err_count=0, expected=0000.
- Acquisition: after reset, feed valid 0000, 0001, 0010, 0100 → the 0000 is ignored; locked=1 the cycle after 0100; expected=1000.
- Single error with flywheel: locked; feed 1000, 1111, 1010, 0001 → err_pulse high exactly once (after 1111), err_count=1, locked stays 1, expected=0010 at end.
- Loss of lock: locked; feed 0111, 0111, 0111 → err_count=3, locked falls after the third beat; next valid 0001 reseeds (expected=0010).
- Gaps and clear: locked, insert in_valid=0 idle cycles between beats → expected does not advance. Assert clr_cnt on the same cycle as a mismatching beat → err_count=0, err_pulse=1.
- Saturation and feature: ERRW=2, LOSS_CNT=8, 5 mismatches → err_count=3. With LFSR_CHK_BITERR_EN, expected 0101 vs received 1010 → bit_err_count +4.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit Galois LFSR generator and checker:
// FSM states, default width/taps and the single next-state function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int LFSR_WIDTH = 4;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 4'b0101;

  // Galois step: shift left, fold the taps in when the MSB falls out.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(
    input logic [LFSR_WIDTH-1:0] s,
    input logic [LFSR_WIDTH-1:0] taps
  );
    logic [LFSR_WIDTH-1:0] r;
    r = {s[LFSR_WIDTH-2:0], 1'b0};
    if (s[LFSR_WIDTH-1]) r = r ^ taps;
    return r;
  endfunction

endpackage

// File: rtl/lfsr_err_counter.sv
// Saturating accumulator with a synchronous clear that wins over a
// simultaneous add. Used for the mismatch and bit-error counters.
module lfsr_err_counter #(
  parameter int W  = 16,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          clr,
  input  logic [AW-1:0] add,
  output logic [W-1:0]  count
);

  localparam int SW = W + AW;
  localparam logic [SW-1:0] MAXV = {{AW{1'b0}}, {W{1'b1}}};

  logic [SW-1:0] sum;

  assign sum = {{AW{1'b0}}, count} + {{W{1'b0}}, add};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (sum > MAXV) begin
      count <= '1;
    end else begin
      count <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/lfsr_4b_checker.sv
// Self-synchronising flywheel checker for the Galois LFSR stream.
// Optional per-bit error accumulation is enabled with LFSR_CHK_BITERR_EN.
//
// state  | meaning
// SEEK   | waiting for a nonzero word to seed the prediction
// SYNC   | seeded; counting consecutive correct predictions
// LOCKED | free-running prediction, mismatches counted
module lfsr_4b_checker
  import lfsr_pkg::*;
#(
  parameter int              WIDTH    = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS    = LFSR_TAPS,
  parameter int              LOCK_CNT = 2,
  parameter int              LOSS_CNT = 3,
  parameter int              ERRW     = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERRW-1:0]  err_count,
  output logic [WIDTH-1:0] expected
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [ERRW-1:0]  bit_err_count
`endif
);

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int XW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;
  localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
  localparam logic [XW-1:0] LOSS_LAST = XW'(LOSS_CNT - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] exp_nx;
  logic [MW-1:0]    match_run, match_nx;
  logic [XW-1:0]    miss_run, miss_nx;
  logic             pulse_nx;
  logic             err_inc;
  logic [WIDTH-1:0] next_in, next_exp;

  assign next_in  = WIDTH'(lfsr_next(LFSR_WIDTH'(in_data), LFSR_WIDTH'(TAPS)));
  assign next_exp = WIDTH'(lfsr_next(LFSR_WIDTH'(expected), LFSR_WIDTH'(TAPS)));
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= SEEK;
      expected  <= '0;
      match_run <= '0;
      miss_run  <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      expected  <= exp_nx;
      match_run <= match_nx;
      miss_run  <= miss_nx;
      err_pulse <= pulse_nx;
    end
  end

  always_comb begin
    state_nx = state;
    exp_nx   = expected;
    match_nx = match_run;
    miss_nx  = miss_run;
    pulse_nx = 1'b0;
    err_inc  = 1'b0;
    if (in_valid) begin
      case (state)
        SEEK: begin
          if (in_data != '0) begin
            exp_nx   = next_in;
            match_nx = '0;
            state_nx = SYNC;
          end
        end
        SYNC: begin
          if (in_data == expected) begin
            exp_nx   = next_in;
            match_nx = match_run + 1'b1;
            if (match_run == LOCK_LAST) begin
              state_nx = LOCKED;
              miss_nx  = '0;
            end
          end else if (in_data == '0) begin
            state_nx = SEEK;
          end else begin
            exp_nx   = next_in;
            match_nx = '0;
          end
        end
        LOCKED: begin
          // flywheel: prediction never reseeds from the received word
          exp_nx = next_exp;
          if (in_data == expected) begin
            miss_nx = '0;
          end else begin
            pulse_nx = 1'b1;
            err_inc  = 1'b1;
            miss_nx  = miss_run + 1'b1;
            if (miss_run == LOSS_LAST) state_nx = SEEK;
          end
        end
        default: state_nx = SEEK;
      endcase
    end
  end

  lfsr_err_counter #(.W(ERRW), .AW(1)) u_err (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (clr_cnt),
    .add   (err_inc),
    .count (err_count)
  );

`ifdef LFSR_CHK_BITERR_EN
  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    pop;
  logic [PW-1:0]    bit_add;

  assign diff = in_data ^ expected;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + PW'(diff[i]);
  end

  assign bit_add = (in_valid && state == LOCKED) ? pop : '0;

  lfsr_err_counter #(.W(ERRW), .AW(PW)) u_bit_err (
    .clk   (clk),
    .nrst  (nrst),
    .clr   (clr_cnt),
    .add   (bit_add),
    .count (bit_err_count)
  );
`endif

endmodule

// File: tb/tb_lfsr_4b_checker.sv
// Bench for lfsr_4b_checker: directed vector table, mid-stream reset,
// randomized stream against an arithmetic reference model, and a
// small-counter instance for saturation.
module tb_lfsr_4b_checker;

  localparam int LOCK_CNT = 2;
  localparam int LOSS_CNT = 3;
  localparam int ERRW     = 16;

  logic        clk = 1'b0;
  logic        nrst, in_valid, clr_cnt;
  logic [3:0]  in_data;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [3:0]  expected;
`ifdef LFSR_CHK_BITERR_EN
  logic [15:0] bit_err_count;
`endif

  logic        s_nrst, s_valid, s_clr;
  logic [3:0]  s_data;
  logic        s_locked, s_pulse;
  logic [1:0]  s_count;
  logic [3:0]  s_expected;
`ifdef LFSR_CHK_BITERR_EN
  logic [1:0]  s_bit_count;
`endif

  always #5 clk = ~clk;

  lfsr_4b_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERRW(ERRW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .expected  (expected)
`ifdef LFSR_CHK_BITERR_EN
    ,
    .bit_err_count (bit_err_count)
`endif
  );

  lfsr_4b_checker #(.LOCK_CNT(2), .LOSS_CNT(8), .ERRW(2)) dut_sat (
    .clk       (clk),
    .nrst      (s_nrst),
    .in_valid  (s_valid),
    .in_data   (s_data),
    .clr_cnt   (s_clr),
    .locked    (s_locked),
    .err_pulse (s_pulse),
    .err_count (s_count),
    .expected  (s_expected)
`ifdef LFSR_CHK_BITERR_EN
    ,
    .bit_err_count (s_bit_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Reference model: plain integer arithmetic over the protocol rules
  int m_mode;   // 0 seek, 1 sync, 2 locked
  int m_exp, m_match, m_miss, m_cnt, m_bits, m_pulse;

  function automatic int nxt(input int s);
    int v;
    v = s * 2;
    if (v >= 16) v = (v - 16) ^ 5;
    return v;
  endfunction

  function automatic int ones(input int x);
    int c = 0;
    for (int b = 0; b < 4; b++) c += (x >> b) & 1;
    return c;
  endfunction

  task automatic model_step(input logic r, input logic v, input int d, input logic c);
    int add, badd, lim;
    add  = 0;
    badd = 0;
    lim  = (1 << ERRW) - 1;
    if (!r) begin
      m_mode = 0; m_exp = 0; m_match = 0; m_miss = 0;
      m_cnt = 0; m_bits = 0; m_pulse = 0;
      return;
    end
    m_pulse = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (d != 0) begin
          m_exp = nxt(d); m_match = 0; m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (d == m_exp) begin
          m_exp = nxt(d);
          m_match++;
          if (m_match == LOCK_CNT) begin
            m_mode = 2; m_miss = 0;
          end
        end else if (d == 0) begin
          m_mode = 0;
        end else begin
          m_exp = nxt(d); m_match = 0;
        end
      end else begin
        badd = ones(d ^ m_exp);
        if (d == m_exp) m_miss = 0;
        else begin
          m_pulse = 1; add = 1; m_miss++;
          if (m_miss == LOSS_CNT) m_mode = 0;
        end
        m_exp = nxt(m_exp);
      end
    end
    if (c) begin
      m_cnt = 0; m_bits = 0;
    end else begin
      m_cnt  = (m_cnt + add > lim) ? lim : m_cnt + add;
      m_bits = (m_bits + badd > lim) ? lim : m_bits + badd;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
    nrst = r; in_valid = v; in_data = d; clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(r, v, int'(d), c);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'(m_mode == 2));
    check({tag, "_pulse"}, 32'(err_pulse), 32'(m_pulse));
    check({tag, "_count"}, 32'(err_count), 32'(m_cnt));
    check({tag, "_expected"}, 32'(expected), 32'(m_exp));
`ifdef LFSR_CHK_BITERR_EN
    check({tag, "_bits"}, 32'(bit_err_count), 32'(m_bits));
`endif
  endtask

  task automatic s_step(input logic r, input logic v, input logic [3:0] d);
    s_nrst = r; s_valid = v; s_data = d; s_clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       c;
    logic       l;
    logic       p;
    int         cnt;
    logic [3:0] e;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [3:0] gen;
    logic       rv, rc, re, rr;
    logic [3:0] rd;

    tbl.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000}); // zero ignored in SEEK
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 4'b0010});
    tbl.push_back('{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 0, 4'b0100});
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 0, 4'b1000}); // lock
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 0, 4'b0101});
    tbl.push_back('{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 1, 4'b1010}); // single error, 4 bits
    tbl.push_back('{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1, 4'b0001});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b1, 1'b0, 1, 4'b0010});
    tbl.push_back('{1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 2, 4'b0100}); // loss sequence
    tbl.push_back('{1'b1, 4'b0111, 1'b0, 1'b1, 1'b1, 3, 4'b1000});
    tbl.push_back('{1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, 4, 4'b0101});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4, 4'b0010}); // reseed
    tbl.push_back('{1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4, 4'b0100});
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 4, 4'b1000});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 4, 4'b1000}); // gaps
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 4, 4'b1000});
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 4, 4'b0101});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 4, 4'b0101});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 4'b1010}); // clear beats increment
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b1010});
    tbl.push_back('{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 0, 4'b0001});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 1'b1, 1, 4'b0010});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 0, 4'b0010}); // idle clear

    s_nrst = 1'b0; s_valid = 1'b0; s_data = 4'b0000; s_clr = 1'b0;

    // reset with activity on the inputs
    step(1'b0, 1'b1, 4'b0101, 1'b0);
    step(1'b0, 1'b1, 4'b0101, 1'b0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_count", 32'(err_count), 32'd0);
    check("rst_expected", 32'(expected), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b1, tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d_locked", i), 32'(locked), 32'(tbl[i].l));
      check($sformatf("vec%0d_pulse", i), 32'(err_pulse), 32'(tbl[i].p));
      check($sformatf("vec%0d_count", i), 32'(err_count), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_expected", i), 32'(expected), 32'(tbl[i].e));
`ifdef LFSR_CHK_BITERR_EN
      if (i == 5) check("bit_err_plus4", 32'(bit_err_count), 32'd4);
`endif
    end

    // mid-stream reset drops lock at once
    step(1'b0, 1'b1, 4'b0010, 1'b0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_count", 32'(err_count), 32'd0);
    check("midrst_expected", 32'(expected), 32'd0);
    step(1'b1, 1'b1, 4'b0010, 1'b0);
    check("midrst_reseed", 32'(expected), 32'b0100);
    check("midrst_unlocked", 32'(locked), 32'd0);

    // randomized stream with error bursts, gaps, clears and rare resets
    gen = 4'b0100;
    for (int i = 0; i < 800; i++) begin
      rr = ($urandom_range(199) != 0);
      rv = ($urandom_range(9) < 8);
      rc = ($urandom_range(24) == 0);
      re = ($urandom_range(9) < (((i % 160) < 30) ? 6 : 1));
      rd = re ? 4'($urandom_range(15)) : gen;
      if (rv) gen = 4'(nxt(int'(gen)));
      step(rr, rv, rd, rc);
      check_model($sformatf("rnd%0d", i));
    end

    // saturation on a 2-bit counter with a long loss window
    nrst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
    s_step(1'b0, 1'b0, 4'b0000);
    s_step(1'b1, 1'b1, 4'b0001);
    s_step(1'b1, 1'b1, 4'b0010);
    s_step(1'b1, 1'b1, 4'b0100);
    check("sat_locked", 32'(s_locked), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      s_step(1'b1, 1'b1, 4'b0000);
      check($sformatf("sat_count%0d", k), 32'(s_count), 32'((k > 3) ? 3 : k));
      check($sformatf("sat_pulse%0d", k), 32'(s_pulse), 32'd1);
    end
    check("sat_still_locked", 32'(s_locked), 32'd1);
`ifdef LFSR_CHK_BITERR_EN
    check("sat_bits", 32'(s_bit_count), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
